icache: RTL and testbench
=========================

# icache

Direct-mapped, single-word-line instruction cache between the CPU core's instruction-fetch port (`rom_ce_o`/`rom_addr_o`/`rom_data_i`) and a slower instruction memory with a request/acknowledge handshake. Hits return the instruction combinationally in the same cycle, matching the zero-wait ROM model. Misses raise a stall request toward `ctrl`, fetch the word from memory, fill the line, and then release the stall.

## Interface

Parameters:
- `INDEX_W`, 6: index bits; the cache has 2^INDEX_W lines of one 32-bit word each.
- `TAG_W`, 30-INDEX_W: tag width, derived (address bits [31:INDEX_W+2]).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `cpu_ce_i` in 1: fetch enable from `pc_reg`.
- `cpu_addr_i` in 32: fetch address; bits [1:0] ignored.
- `cpu_data_o` out 32: instruction to `if_id`.
- `stallreq_o` out 1: stall request to `ctrl`.
- `flush_i` in 1: invalidate all lines.
- `mem_req_o` out 1: memory read request.
- `mem_addr_o` out 32: memory word address, with [1:0] = 0.
- `mem_data_i` in 32: memory read data, valid when `mem_ack_i` = 1.
- `mem_ack_i` in 1: memory acknowledge, a one-cycle pulse.

## Operation

- Arrays:
  - `valid[2^INDEX_W]` is reset to 0.
  - `tag[]` and `data[]` are not reset.
- Address split: index = addr[INDEX_W+1:2]; tag = addr[31:INDEX_W+2].
- Hit, combinational: `cpu_ce_i` & state==IDLE & `valid[index]` & `tag[index]`==tag.
- FSM has two states, IDLE and FETCH.
- IDLE:
  - `cpu_ce_i`=0: `cpu_data_o`=0, `stallreq_o`=0, no action.
  - Hit: `cpu_data_o`=`data[index]`, `stallreq_o`=0.
  - Miss: `cpu_data_o`=0, `stallreq_o`=1 in the same cycle. Latch {tag, index} into `miss_addr`, then go to FETCH.
- FETCH:
  - Drive `mem_req_o`=1 and `mem_addr_o`={`miss_addr`,2'b00}, both registered.
  - `stallreq_o`=1 and `cpu_data_o`=0.
  - `cpu_addr_i` is ignored; the core is stalled and holds it.
  - On `mem_ack_i`=1:
    - write `data[idx]`=`mem_data_i` and `tag[idx]`=latched tag;
    - set `valid[idx]`=1;
    - drop `mem_req_o` at the same edge;
    - return to IDLE.
  - The next IDLE cycle re-looks-up the current address. This normally hits, and `stallreq_o` drops.
- `mem_ack_i` while in IDLE: ignored.
- Flush:
  - `flush_i`=1 clears every valid bit at the next edge, in any state.
  - If `flush_i` and `mem_ack_i` coincide, flush wins: the filled line stays invalid, and the following lookup misses and refetches.
  - `flush_i` does not abort a FETCH in progress.
- Conflict: a fill to an occupied index overwrites it.
- Reset, including mid-FETCH:
  - state=IDLE, `mem_req_o`=0, `mem_addr_o`=0, all valid bits = 0.
  - An ack that arrives after reset in IDLE is ignored.

## Timing

- Reset values:
  - `mem_req_o`=0, `mem_addr_o`=0.
  - `stallreq_o`=0, `cpu_data_o`=0, since the cache is in IDLE with all lines invalid.
- Hit latency is 0 cycles; the output is combinational from `cpu_addr_i`.
- Miss timeline, for an ack at cycle A ≥ 1:
  - Cycle 0: miss detected, `stallreq_o`=1.
  - Cycle 1: `mem_req_o`=1.
  - Cycle A: `mem_ack_i`=1.
  - Cycle A+1: IDLE and hit, `stallreq_o`=0, data valid.
  - The minimum miss penalty is 2 stall cycles (ack in cycle 1).
- `mem_req_o` and `mem_addr_o` are held stable from cycle 1 until the ack cycle inclusive.
- The memory may hold the ack off indefinitely.
- `stallreq_o` is combinational from the state and the hit logic. There is no combinational path from `mem_*` inputs to `stallreq_o`.

## Test plan

- **Cold miss:** reset, then `cpu_ce_i`=1, addr=0x00000010; memory acks in cycle 1 with 0x34010001.
  - Expect `stallreq_o`=1 for cycles 0–1 and `mem_addr_o`=0x10.
  - In cycle 2: `stallreq_o`=0 and `cpu_data_o`=0x34010001.
- **Hit:** repeat addr 0x10. Expect `stallreq_o`=0, data 0x34010001, and `mem_req_o` never asserted.
- **Conflict and delayed ack** (INDEX_W=6): fetch 0x10, then 0x110 (same index), with the ack delayed 5 cycles carrying 0xAAAA5555.
  - Expect the stall to last 6 cycles and 0x110 to return 0xAAAA5555.
  - A re-fetch of 0x10 misses again.
- **Flush:** fill 0x10, pulse `flush_i`, fetch 0x10. Expect a miss and a new `mem_req_o`.
  - Flush coincident with ack: the next cycle still misses and refetches.
- **Reset mid-FETCH:** drop `rst` to 0 while `mem_req_o`=1.
  - Expect `mem_req_o`=0 and `stallreq_o`=0 immediately (asynchronously).
  - Pulse `mem_ack_i` after release: no line becomes valid, and fetching 0x10 misses.
- **ce low:** `cpu_ce_i`=0 with any address. Expect `cpu_data_o`=0, `stallreq_o`=0, and no request.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache with one 32-bit word per line.
// Hits are answered combinationally; misses stall the core and fetch the word through a req/ack port.
module icache #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e             state_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];
  logic [TAG_W-1:0]   miss_tag_q;
  logic [INDEX_W-1:0] miss_idx_q;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               miss;
  logic               fill;
  logic               unused_addr_lsb;

  assign idx             = cpu_addr_i[INDEX_W+1:2];
  assign tag             = cpu_addr_i[31:INDEX_W+2];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  assign hit  = cpu_ce_i && (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
  assign miss = cpu_ce_i && (state_q == IDLE) && !hit;
  assign fill = (state_q == FETCH) && mem_ack_i;

  assign cpu_data_o = hit ? data_q[idx] : 32'h0;
  // Held in reset the core sees no stall, even if it is still presenting a fetch.
  assign stallreq_o = rst && (miss || (state_q == FETCH));
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            state_q    <= FETCH;
            miss_tag_q <= tag;
            miss_idx_q <= idx;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {tag, idx, 2'b00};
          end
        end
        FETCH: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flush takes priority over a coinciding fill, leaving the new line invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[miss_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[miss_idx_q]  <= miss_tag_q;
      data_q[miss_idx_q] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, delayed ack, flush, reset mid-fetch, ce low.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  icache #(.INDEX_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .flush_i    (flush_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every task starts and ends 1ns after a rising edge; checks happen on the falling edge.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input string nm, input logic [31:0] a, input logic [31:0] d, input int dly);
    cpu_ce_i   = 1'b1;
    cpu_addr_i = a;
    @(negedge clk);
    chk($sformatf("%s.c0.stall", nm), {31'h0, stallreq_o}, 32'h1);
    chk($sformatf("%s.c0.data", nm), cpu_data_o, 32'h0);
    chk($sformatf("%s.c0.req", nm), {31'h0, mem_req_o}, 32'h0);
    cyc;
    for (int k = 1; k <= dly; k++) begin
      if (k == dly) begin
        mem_ack_i  = 1'b1;
        mem_data_i = d;
      end
      @(negedge clk);
      chk($sformatf("%s.c%0d.req", nm, k), {31'h0, mem_req_o}, 32'h1);
      chk($sformatf("%s.c%0d.addr", nm, k), mem_addr_o, {a[31:2], 2'b00});
      chk($sformatf("%s.c%0d.stall", nm, k), {31'h0, stallreq_o}, 32'h1);
      chk($sformatf("%s.c%0d.data", nm, k), cpu_data_o, 32'h0);
      cyc;
      mem_ack_i = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("%s.done.stall", nm), {31'h0, stallreq_o}, 32'h0);
    chk($sformatf("%s.done.data", nm), cpu_data_o, d);
    chk($sformatf("%s.done.req", nm), {31'h0, mem_req_o}, 32'h0);
    cyc;
  endtask

  task automatic expect_hit(input string nm, input logic [31:0] a, input logic [31:0] d, input int n);
    cpu_ce_i   = 1'b1;
    cpu_addr_i = a;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("%s.%0d.stall", nm, k), {31'h0, stallreq_o}, 32'h0);
      chk($sformatf("%s.%0d.data", nm, k), cpu_data_o, d);
      chk($sformatf("%s.%0d.req", nm, k), {31'h0, mem_req_o}, 32'h0);
      cyc;
    end
  endtask

  initial begin
    rst        = 1'b0;
    cpu_ce_i   = 1'b0;
    cpu_addr_i = 32'h0;
    flush_i    = 1'b0;
    mem_data_i = 32'h0;
    mem_ack_i  = 1'b0;

    @(negedge clk);
    chk("rst.req", {31'h0, mem_req_o}, 32'h0);
    chk("rst.addr", mem_addr_o, 32'h0);
    chk("rst.stall", {31'h0, stallreq_o}, 32'h0);
    chk("rst.data", cpu_data_o, 32'h0);
    cyc;
    rst = 1'b1;
    cyc;

    do_miss("cold", 32'h0000_0010, 32'h3401_0001, 1);
    expect_hit("hit", 32'h0000_0010, 32'h3401_0001, 3);

    // ce low: nothing is returned or requested, even for a cached address.
    cpu_ce_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cpu_addr_i = (k == 0) ? 32'h0000_0010 : 32'h0000_0774;
      @(negedge clk);
      chk($sformatf("ce0.%0d.data", k), cpu_data_o, 32'h0);
      chk($sformatf("ce0.%0d.stall", k), {31'h0, stallreq_o}, 32'h0);
      chk($sformatf("ce0.%0d.req", k), {31'h0, mem_req_o}, 32'h0);
      cyc;
    end

    // Ack while idle must not disturb anything.
    mem_ack_i  = 1'b1;
    mem_data_i = 32'hFFFF_0000;
    cyc;
    mem_ack_i  = 1'b0;
    expect_hit("idleack", 32'h0000_0010, 32'h3401_0001, 1);

    do_miss("conf", 32'h0000_0110, 32'hAAAA_5555, 5);
    expect_hit("confhit", 32'h0000_0110, 32'hAAAA_5555, 1);
    do_miss("refetch", 32'h0000_0010, 32'h3401_0001, 1);
    do_miss("other", 32'h0000_0014, 32'h1111_2222, 2);
    expect_hit("keep10", 32'h0000_0010, 32'h3401_0001, 1);
    expect_hit("keep14", 32'h0000_0014, 32'h1111_2222, 1);

    cpu_ce_i = 1'b0;
    flush_i  = 1'b1;
    cyc;
    flush_i = 1'b0;
    do_miss("flush", 32'h0000_0010, 32'h3401_0002, 3);

    // Flush coincident with the fill ack: the line stays invalid and is refetched.
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h0000_0020;
    @(negedge clk);
    chk("fa.c0.stall", {31'h0, stallreq_o}, 32'h1);
    cyc;
    mem_ack_i  = 1'b1;
    flush_i    = 1'b1;
    mem_data_i = 32'h5566_7788;
    @(negedge clk);
    chk("fa.c1.req", {31'h0, mem_req_o}, 32'h1);
    cyc;
    mem_ack_i = 1'b0;
    flush_i   = 1'b0;
    @(negedge clk);
    chk("fa.c2.stall", {31'h0, stallreq_o}, 32'h1);
    chk("fa.c2.data", cpu_data_o, 32'h0);
    chk("fa.c2.req", {31'h0, mem_req_o}, 32'h0);
    cyc;
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h5566_7789;
    @(negedge clk);
    chk("fa.c3.req", {31'h0, mem_req_o}, 32'h1);
    chk("fa.c3.addr", mem_addr_o, 32'h0000_0020);
    cyc;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("fa.c4.stall", {31'h0, stallreq_o}, 32'h0);
    chk("fa.c4.data", cpu_data_o, 32'h5566_7789);
    cyc;

    // Reset asserted in the middle of a fetch.
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h0000_0030;
    @(negedge clk);
    chk("rf.c0.stall", {31'h0, stallreq_o}, 32'h1);
    cyc;
    @(negedge clk);
    chk("rf.c1.req", {31'h0, mem_req_o}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rf.async.req", {31'h0, mem_req_o}, 32'h0);
    chk("rf.async.addr", mem_addr_o, 32'h0);
    chk("rf.async.stall", {31'h0, stallreq_o}, 32'h0);
    cyc;
    rst        = 1'b1;
    cpu_ce_i   = 1'b0;
    mem_ack_i  = 1'b1;
    mem_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rf.ack.req", {31'h0, mem_req_o}, 32'h0);
    chk("rf.ack.stall", {31'h0, stallreq_o}, 32'h0);
    cyc;
    mem_ack_i = 1'b0;
    do_miss("rf.10", 32'h0000_0010, 32'h3401_0003, 1);
    do_miss("rf.30", 32'h0000_0030, 32'h0BAD_F00D, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
